// File: rtl/hls_run_sequencer.sv
// Run sequencer for the HLS compute core: pulses start once per run, captures each
// return value into a valid/ready result stream, guards runs with a watchdog and
// supports a graceful abort that lets the in-flight run finish.
module hls_run_sequencer #(
  parameter int          RET_W   = 32,
  parameter int          CNT_W   = 16,
  parameter int          TMO_W   = 24,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             core_start,
  input  logic             core_done,
  input  logic [RET_W-1:0] core_return,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RET_W-1:0] res_data,
  output logic [CNT_W-1:0] res_index,
  output logic             res_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] runs_done
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_EMIT
  } state_e;

  state_e state_q, state_d;

  logic [TMO_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] res_index_q, res_index_d;
  logic [RET_W-1:0] res_data_q, res_data_d;
  logic             res_timeout_q, res_timeout_d;
  logic [CNT_W-1:0] runs_done_q, runs_done_d;
  logic             abort_pending_q, abort_pending_d;

  logic cmd_fire;
  logic timer_expired;
  logic last_run;

  assign cmd_fire      = cmd_valid && (cmd_count != '0);
  assign timer_expired = (timer_q == TMO_LAST);
  // A timeout or a pending abort ends the whole command, not just this run.
  assign last_run      = (remaining_q == CNT_W'(1)) || res_timeout_q || abort_pending_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done || timer_expired) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          state_d = last_run ? S_IDLE : S_START;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    core_start = (state_q == S_START);
    res_valid  = (state_q == S_EMIT);
    busy       = (state_q != S_IDLE);
  end

  always_comb begin
    timer_d         = timer_q;
    remaining_d     = remaining_q;
    res_index_d     = res_index_q;
    res_data_d      = res_data_q;
    res_timeout_d   = res_timeout_q;
    runs_done_d     = runs_done_q;
    abort_pending_d = abort_pending_q;

    if ((state_q != S_IDLE) && abort) begin
      abort_pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          remaining_d = cmd_count;
          res_index_d = '0;
        end
      end
      S_START: begin
        timer_d = '0;
      end
      S_WAIT: begin
        // core_done wins over a watchdog expiry landing in the same cycle.
        if (core_done) begin
          res_data_d    = core_return;
          res_timeout_d = 1'b0;
          runs_done_d   = runs_done_q + CNT_W'(1);
        end else if (timer_expired) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TMO_W'(1);
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (last_run) begin
            abort_pending_d = 1'b0;
          end else begin
            res_index_d = res_index_q + CNT_W'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q         <= '0;
      remaining_q     <= '0;
      res_index_q     <= '0;
      res_data_q      <= '0;
      res_timeout_q   <= 1'b0;
      runs_done_q     <= '0;
      abort_pending_q <= 1'b0;
    end else begin
      timer_q         <= timer_d;
      remaining_q     <= remaining_d;
      res_index_q     <= res_index_d;
      res_data_q      <= res_data_d;
      res_timeout_q   <= res_timeout_d;
      runs_done_q     <= runs_done_d;
      abort_pending_q <= abort_pending_d;
    end
  end

  assign res_data    = res_data_q;
  assign res_index   = res_index_q;
  assign res_timeout = res_timeout_q;
  assign runs_done   = runs_done_q;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Self-checking bench for hls_run_sequencer: a behavioural core model, a start/result
// monitor, a table of command scenarios and hand-written timing/abort/reset sequences.
module tb_hls_run_sequencer;

  localparam int RET_W   = 32;
  localparam int CNT_W   = 16;
  localparam int TMO_W   = 24;
  localparam int TIMEOUT = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             core_start;
  logic             core_done;
  logic [RET_W-1:0] core_return;
  logic             res_valid;
  logic             res_ready;
  logic [RET_W-1:0] res_data;
  logic [CNT_W-1:0] res_index;
  logic             res_timeout;
  logic             busy;
  logic [CNT_W-1:0] runs_done;

  hls_run_sequencer #(
    .RET_W(RET_W), .CNT_W(CNT_W), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
    .abort(abort),
    .core_start(core_start), .core_done(core_done), .core_return(core_return),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_index(res_index), .res_timeout(res_timeout),
    .busy(busy), .runs_done(runs_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [RET_W-1:0] data;
    logic [CNT_W-1:0] idx;
    logic             to;
    int               cyc;
  } res_t;

  typedef struct {
    int               count;
    int               delay;
    logic [RET_W-1:0] base;
    int               exp_starts;
    int               exp_results;
    bit               exp_to;
    int               exp_runs;
  } vec_t;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  int   start_cnt = 0;
  int   start_cyc[$];
  res_t res_q[$];

  // Core model: done arrives core_delay cycles after the start pulse (0 = never).
  int               core_delay = 0;
  logic [RET_W-1:0] ret_base   = '0;
  int               ret_idx    = 0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    core_done   = 1'b0;
    core_return = '0;
    forever begin
      @(negedge clock);
      if (!reset && core_start && core_delay > 0) begin
        repeat (core_delay) @(posedge clock);
        #1;
        core_done   = 1'b1;
        core_return = ret_base * 32'(ret_idx + 1);
        ret_idx++;
        @(posedge clock);
        #1;
        core_done   = 1'b0;
        core_return = '0;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (core_start) begin
        start_cnt++;
        start_cyc.push_back(cyc);
      end
      if (res_valid && res_ready) begin
        res_q.push_back('{data: res_data, idx: res_index, to: res_timeout, cyc: cyc});
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sampleEdge();
    @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int count, output int accept_cyc);
    @(posedge clock);
    #1;
    cmd_valid  = 1'b1;
    cmd_count  = CNT_W'(count);
    accept_cyc = cyc;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_count = '0;
  endtask

  task automatic waitIdle(input int max_cycles, output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < max_cycles; i++) begin
      sampleEdge();
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
    end
    if (idle_cyc < 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL wait_idle: busy still 1 after %0d cycles, expected 0", max_cycles);
    end
  endtask

  task automatic waitStarts(input int target, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      sampleEdge();
      if (start_cnt >= target) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      failed++;
      $display("[TB] FAIL wait_starts: start count %0d, expected %0d", start_cnt, target);
    end
  endtask

  task automatic waitValid(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      sampleEdge();
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      failed++;
      $display("[TB] FAIL wait_valid: res_valid 0 after %0d cycles, expected 1", max_cycles);
    end
  endtask

  function automatic res_t getRes(input int k);
    res_t r;
    r = '{data: '1, idx: '1, to: 1'bx, cyc: -1};
    if (k >= 0 && k < res_q.size()) r = res_q[k];
    return r;
  endfunction

  function automatic int getStart(input int k);
    if (k >= 0 && k < start_cyc.size()) return start_cyc[k];
    return -1;
  endfunction

  initial begin
    vec_t vecs[7];
    int   acc;
    int   idle_cyc;
    int   s0;
    int   r0;
    int   rise_cyc;
    logic [CNT_W-1:0] rd0;
    res_t r;

    vecs[0] = '{3, 5,  32'h11,   3, 3, 1'b0, 3};
    vecs[1] = '{0, 5,  32'h22,   0, 0, 1'b0, 0};
    vecs[2] = '{1, 1,  32'hA5,   1, 1, 1'b0, 1};
    vecs[3] = '{2, 2,  32'h1000, 2, 2, 1'b0, 2};
    vecs[4] = '{4, 0,  32'h0,    1, 1, 1'b1, 0};
    vecs[5] = '{2, 16, 32'h7,    2, 2, 1'b0, 2};
    vecs[6] = '{2, 17, 32'h9,    1, 1, 1'b1, 0};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = '0;
    abort     = 1'b0;
    res_ready = 1'b1;
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_core_start", core_start, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_res_index", res_index, 0);
    checkOutput("rst_res_timeout", res_timeout, 0);
    checkOutput("rst_runs_done", runs_done, 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Three back-to-back runs with exact handshake latencies.
    $display("[TB] sequence: three runs, latency");
    s0 = start_cnt; r0 = res_q.size();
    core_delay = 5; ret_base = 32'h11; ret_idx = 0;
    applyStimulus(3, acc);
    waitIdle(200, idle_cyc);
    checkOutput("t1_start0_lat", 64'(getStart(s0)), 64'(acc + 1));
    checkOutput("t1_res0_lat", 64'(getRes(r0).cyc), 64'(getStart(s0) + 6));
    checkOutput("t1_start1_lat", 64'(getStart(s0 + 1)), 64'(getRes(r0).cyc + 1));
    checkOutput("t1_start2_lat", 64'(getStart(s0 + 2)), 64'(getRes(r0 + 1).cyc + 1));
    checkOutput("t1_idle_lat", 64'(idle_cyc), 64'(getRes(r0 + 2).cyc + 1));
    checkOutput("t1_cmd_ready", cmd_ready, 1);
    checkOutput("t1_runs_done", runs_done, 3);
    for (int i = 0; i < 3; i++) begin
      r = getRes(r0 + i);
      checkOutput($sformatf("t1_data%0d", i), r.data, 64'(32'h11 * (i + 1)));
      checkOutput($sformatf("t1_idx%0d", i), r.idx, 64'(i));
      checkOutput($sformatf("t1_to%0d", i), r.to, 0);
    end

    // Watchdog expiry timing with a silent core.
    $display("[TB] sequence: watchdog timing");
    s0 = start_cnt; r0 = res_q.size(); rd0 = runs_done;
    core_delay = 0; ret_idx = 0;
    applyStimulus(4, acc);
    waitIdle(200, idle_cyc);
    repeat (5) sampleEdge();
    checkOutput("t3_starts", 64'(start_cnt - s0), 1);
    checkOutput("t3_results", 64'(res_q.size() - r0), 1);
    checkOutput("t3_res_lat", 64'(getRes(r0).cyc), 64'(getStart(s0) + TIMEOUT + 1));
    checkOutput("t3_data", getRes(r0).data, 0);
    checkOutput("t3_to", getRes(r0).to, 1);
    checkOutput("t3_runs", 64'(16'(runs_done - rd0)), 0);

    $display("[TB] table of command scenarios");
    for (int v = 0; v < 7; v++) begin
      s0 = start_cnt; r0 = res_q.size(); rd0 = runs_done;
      core_delay = vecs[v].delay; ret_base = vecs[v].base; ret_idx = 0; res_ready = 1'b1;
      applyStimulus(vecs[v].count, acc);
      waitIdle(200, idle_cyc);
      repeat (3) sampleEdge();
      checkOutput($sformatf("v%0d_starts", v), 64'(start_cnt - s0), 64'(vecs[v].exp_starts));
      checkOutput($sformatf("v%0d_results", v), 64'(res_q.size() - r0), 64'(vecs[v].exp_results));
      checkOutput($sformatf("v%0d_runs", v), 64'(16'(runs_done - rd0)), 64'(vecs[v].exp_runs));
      checkOutput($sformatf("v%0d_busy", v), busy, 0);
      for (int i = 0; i < vecs[v].exp_results; i++) begin
        bit is_to;
        is_to = vecs[v].exp_to && (i == vecs[v].exp_results - 1);
        r = getRes(r0 + i);
        checkOutput($sformatf("v%0d_data%0d", v, i), r.data,
                    is_to ? 64'(0) : 64'(vecs[v].base * 32'(i + 1)));
        checkOutput($sformatf("v%0d_idx%0d", v, i), r.idx, 64'(i));
        checkOutput($sformatf("v%0d_to%0d", v, i), r.to, 64'(is_to));
      end
    end

    // Backpressure: result held stable, no next start until the handshake.
    $display("[TB] sequence: result backpressure");
    s0 = start_cnt; r0 = res_q.size();
    core_delay = 3; ret_base = 32'h50; ret_idx = 0; res_ready = 1'b0;
    applyStimulus(2, acc);
    waitValid(50);
    for (int i = 0; i < 10; i++) begin
      sampleEdge();
      checkOutput($sformatf("t4_valid_c%0d", i), res_valid, 1);
      checkOutput($sformatf("t4_data_c%0d", i), res_data, 32'h50);
      checkOutput($sformatf("t4_idx_c%0d", i), res_index, 0);
    end
    checkOutput("t4_no_early_start", 64'(start_cnt - s0), 1);
    @(posedge clock);
    #1;
    res_ready = 1'b1;
    rise_cyc  = cyc;
    waitStarts(s0 + 2, 20);
    checkOutput("t4_start1_lat", 64'(getStart(s0 + 1)), 64'(rise_cyc + 1));
    waitIdle(100, idle_cyc);
    checkOutput("t4_data1", getRes(r0 + 1).data, 32'hA0);
    checkOutput("t4_idx1", getRes(r0 + 1).idx, 1);

    // Abort during the second run: it completes and is emitted, then stop.
    $display("[TB] sequence: graceful abort");
    s0 = start_cnt; r0 = res_q.size(); rd0 = runs_done;
    core_delay = 5; ret_base = 32'h3; ret_idx = 0; res_ready = 1'b1;
    applyStimulus(5, acc);
    waitStarts(s0 + 2, 100);
    @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    waitIdle(200, idle_cyc);
    repeat (10) sampleEdge();
    checkOutput("t5_starts", 64'(start_cnt - s0), 2);
    checkOutput("t5_results", 64'(res_q.size() - r0), 2);
    checkOutput("t5_runs", 64'(16'(runs_done - rd0)), 2);
    checkOutput("t5_data1", getRes(r0 + 1).data, 32'h6);
    checkOutput("t5_idx1", getRes(r0 + 1).idx, 1);
    checkOutput("t5_to1", getRes(r0 + 1).to, 0);

    // Asynchronous reset in the middle of a wait.
    $display("[TB] sequence: async reset mid-run");
    s0 = start_cnt;
    core_delay = 8; ret_base = 32'h44; ret_idx = 0;
    applyStimulus(3, acc);
    waitStarts(s0 + 1, 20);
    repeat (2) sampleEdge();
    checkOutput("t6_busy_before", busy, 1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6_core_start", core_start, 0);
    checkOutput("t6_res_valid", res_valid, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_runs_done", runs_done, 0);
    checkOutput("t6_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (12) sampleEdge();
    r0 = res_q.size();
    core_delay = 3; ret_base = 32'h99; ret_idx = 0;
    applyStimulus(1, acc);
    waitIdle(100, idle_cyc);
    checkOutput("t6_results", 64'(res_q.size() - r0), 1);
    checkOutput("t6_data", getRes(r0).data, 32'h99);
    checkOutput("t6_idx", getRes(r0).idx, 0);
    checkOutput("t6_runs_after", runs_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hls_run_sequencer.md
Name: hls_run_sequencer

Overview:
Sequences the HLS-generated compute core through its start/done/return handshake. Accepts a run command carrying a repeat count and pulses the core's start once per run. Captures each return value into a valid/ready result stream, guards every run with a timeout watchdog, and supports a graceful abort. Sits between the host/debug command path and the core inside the top-level wrapper.

Parameters:
RET_W, 32, width of core return value and result data
CNT_W, 16, width of repeat count, result index and run counter
TMO_W, 24, width of watchdog timer
TIMEOUT, 1000000, cycles allowed in WAIT before a run is declared hung (1..2^TMO_W-1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  run command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_count  in  CNT_W  number of back-to-back runs
abort  in  1  request to stop after the current run
core_start  out  1  one-cycle start pulse to core start_port
core_done  in  1  core done_port
core_return  in  RET_W  core return_port, valid when core_done=1
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  RET_W  captured return value (0 on timeout)
res_index  out  CNT_W  run index within current command, from 0
res_timeout  out  1  result produced by watchdog, not by core
busy  out  1  state != IDLE
runs_done  out  CNT_W  total core-completed runs since reset, wraps

Behaviour:
- Reset (async assert, sync release): state=IDLE; core_start, res_valid, res_timeout, busy = 0; res_data, res_index, runs_done, timer, remaining = 0; abort_pending=0. cmd_ready = (state==IDLE), so it reads 1 during reset.
- IDLE: cmd_ready=1. abort is ignored.
  - Command accepted with cmd_count=0: dropped, stay IDLE, no start, no result.
  - Command accepted with cmd_count>0: remaining=cmd_count, res_index=0, go START.
- START: core_start=1 for exactly this cycle; timer=0; go WAIT. core_done in this cycle is ignored.
- WAIT: core_start=0.
  - core_done=1: res_data=core_return, res_timeout=0, runs_done+1, go EMIT.
  - Else if timer==TIMEOUT-1: res_data=0, res_timeout=1, go EMIT.
  - Else timer+1.
  - core_done takes priority when it coincides with timer expiry.
- EMIT: res_valid=1. res_data, res_index and res_timeout are held stable until res_valid && res_ready.
  - On the handshake: res_valid=0, remaining-1.
  - Go IDLE if remaining was 1, res_timeout=1, or abort_pending=1; clear abort_pending on that exit.
  - Otherwise res_index+1 and go START.
- abort: any cycle with abort=1 in START, WAIT or EMIT sets abort_pending. The core cannot be killed, so the in-flight run still completes (or times out), its result is emitted, then the sequencer returns to IDLE.
- Timeout terminates the whole command. The remaining runs are discarded.
- Latencies:
  - Command accepted in cycle N gives core_start=1 in cycle N+1.
  - core_done in cycle M gives res_valid=1 in cycle M+1.
  - Result handshake in cycle K gives the next core_start in cycle K+1.
- Counters use CNT_W-bit modular arithmetic. runs_done wraps from 2^CNT_W-1 to 0. Timeout results do not increment runs_done.
- Async reset mid-run returns to IDLE immediately. Any partially emitted result is lost and core_start is deasserted combinationally with reset.

Test Plan:
1. cmd_count=3; core asserts done 5 cycles after each start, returning 0x11, 0x22, 0x33; res_ready=1 -> three core_start pulses, results (0x11,idx0), (0x22,idx1), (0x33,idx2), res_timeout=0, runs_done=3, busy=0 and cmd_ready=1 the cycle after the last handshake.
2. cmd_count=0 accepted -> no core_start, no res_valid, busy stays 0, runs_done unchanged.
3. TIMEOUT=16, cmd_count=4, core never done -> res_valid with res_data=0, res_timeout=1, idx0 asserted 17 cycles after the start pulse; after the handshake, IDLE with no further starts; runs_done=0.
4. cmd_count=2, res_ready held low 10 cycles on first result -> res_data, res_index stable and res_valid high throughout; no second core_start until 1 cycle after res_ready rises.
5. cmd_count=5, abort pulsed during WAIT of run idx1 -> idx1 result emitted normally, then IDLE, runs_done=2, only 2 start pulses total.
6. Async reset asserted mid-WAIT of a 3-run command -> core_start, res_valid, busy, runs_done read 0 in the same cycle; cmd_ready=1; a new cmd_count=1 after release runs cleanly with res_index=0.
